// File: rtl/ps2_voice_allocator.sv
// PS/2 scan-code decoder with polyphony-limited voice allocation for 10 piano keys.
// Define VOICE_STEAL_EN so that a new key steals the oldest voice when every voice is busy.
module ps2_voice_allocator #(
  parameter int NUM_VOICES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              ps2_key_data,
  input  logic                    ps2_key_pressed,
  output logic [9:0]              keys_out,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [4*NUM_VOICES-1:0] voice_key,
  output logic [NUM_VOICES-1:0]   voice_start
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } dec_state_t;

  dec_state_t state, state_next;
  logic make_ev, break_ev;

  logic       key_mapped;
  logic [3:0] key_idx;

  logic                  any_free;
  logic [NUM_VOICES-1:0] free_oh;
  logic [NUM_VOICES-1:0] hit_oh;
  logic [NUM_VOICES-1:0] alloc_oh;
  logic                  do_make, do_break;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    make_ev    = 1'b0;
    break_ev   = 1'b0;
    if (ps2_key_pressed) begin
      case (state)
        S_IDLE: begin
          if (ps2_key_data == 8'hF0)      state_next = S_BREAK;
          else if (ps2_key_data == 8'hE0) state_next = S_EXT;
          else                            make_ev    = 1'b1;
        end
        S_BREAK: begin
          break_ev   = 1'b1;
          state_next = S_IDLE;
        end
        S_EXT: begin
          if (ps2_key_data == 8'hF0) state_next = S_EXT_BREAK;
          else                       state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    key_mapped = 1'b1;
    key_idx    = '0;
    case (ps2_key_data)
      8'h1A:   key_idx = 4'd9;
      8'h1B:   key_idx = 4'd8;
      8'h22:   key_idx = 4'd7;
      8'h23:   key_idx = 4'd6;
      8'h21:   key_idx = 4'd5;
      8'h2A:   key_idx = 4'd4;
      8'h34:   key_idx = 4'd3;
      8'h32:   key_idx = 4'd2;
      8'h33:   key_idx = 4'd1;
      8'h31:   key_idx = 4'd0;
      default: key_mapped = 1'b0;
    endcase
  end

  always_comb begin
    free_oh  = '0;
    any_free = 1'b0;
    hit_oh   = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (!voice_gate[v] && !any_free) begin
        free_oh[v] = 1'b1;
        any_free   = 1'b1;
      end
      hit_oh[v] = voice_gate[v] && (voice_key[4*v +: 4] == key_idx);
    end
  end

  // Typematic repeats of a held key are filtered out before any allocation.
  assign do_make  = make_ev && key_mapped && !keys_out[key_idx];
  assign do_break = break_ev && key_mapped;

`ifdef VOICE_STEAL_EN
  logic [2:0]            rank [NUM_VOICES];
  logic [NUM_VOICES-1:0] oldest_oh;
  logic [2:0]            alloc_rank;

  always_comb begin
    oldest_oh  = '0;
    alloc_rank = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++)
      oldest_oh[v] = (rank[v] == 3'(NUM_VOICES - 1));
    alloc_oh = any_free ? free_oh : oldest_oh;
    for (int unsigned v = 0; v < NUM_VOICES; v++)
      if (alloc_oh[v]) alloc_rank = alloc_rank | rank[v];
  end

  // Younger voices age by one; the allocated voice becomes the youngest.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) rank[v] <= 3'(v);
    end else if (do_make) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (alloc_oh[v])                rank[v] <= '0;
        else if (rank[v] < alloc_rank)  rank[v] <= rank[v] + 3'd1;
      end
    end
  end
`else
  always_comb alloc_oh = free_oh;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      keys_out    <= '0;
      voice_gate  <= '0;
      voice_key   <= '0;
      voice_start <= '0;
    end else begin
      voice_start <= '0;
      if (do_make) begin
        keys_out[key_idx] <= 1'b1;
        voice_start       <= alloc_oh;
        voice_gate        <= voice_gate | alloc_oh;
        for (int unsigned v = 0; v < NUM_VOICES; v++)
          if (alloc_oh[v]) voice_key[4*v +: 4] <= key_idx;
      end
      if (do_break) begin
        keys_out[key_idx] <= 1'b0;
        voice_gate        <= voice_gate & ~hit_oh;
      end
    end
  end

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Randomised self-checking bench for ps2_voice_allocator against a queue-based voice model.
module tb_ps2_voice_allocator;
  localparam int NV = 4;
  localparam int VW = 10 + 6 * NV;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        ps2_key_data = '0;
  logic              ps2_key_pressed = 1'b0;
  logic [9:0]        keys_out;
  logic [NV-1:0]     voice_gate;
  logic [4*NV-1:0]   voice_key;
  logic [NV-1:0]     voice_start;

  int checks = 0;
  int failures = 0;

  ps2_voice_allocator #(.NUM_VOICES(NV)) dut (
    .clock           (clock),
    .reset           (reset),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .keys_out        (keys_out),
    .voice_gate      (voice_gate),
    .voice_key       (voice_key),
    .voice_start     (voice_start)
  );

  always #5 clock = ~clock;

  // Reference model: prefix flags, held-key set, per-voice slot, recency queue (front = newest).
  logic [7:0] codes [10] = '{8'h31, 8'h33, 8'h32, 8'h34, 8'h2A, 8'h21, 8'h23, 8'h22, 8'h1B, 8'h1A};
  bit m_keys [10];
  bit m_gate [NV];
  int m_vk   [NV];
  bit m_start[NV];
  int age_q[$];
  bit m_brk, m_ext;

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 10; i++) if (codes[i] == b) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 10; i++) m_keys[i] = 0;
    age_q = {};
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 0; m_vk[v] = 0; m_start[v] = 0;
      age_q.push_back(v);
    end
    m_brk = 0; m_ext = 0;
  endfunction

  function automatic void model_make(input int k);
    int v;
    if (k < 0 || m_keys[k]) return;
    m_keys[k] = 1;
    v = -1;
    for (int i = NV - 1; i >= 0; i--) if (!m_gate[i]) v = i;
`ifdef VOICE_STEAL_EN
    if (v < 0) v = age_q[$];
`endif
    if (v < 0) return;
    m_gate[v] = 1; m_vk[v] = k; m_start[v] = 1;
    for (int i = 0; i < age_q.size(); i++)
      if (age_q[i] == v) begin age_q.delete(i); break; end
    age_q.push_front(v);
  endfunction

  function automatic void model_break(input int k);
    if (k < 0) return;
    m_keys[k] = 0;
    for (int v = 0; v < NV; v++) if (m_gate[v] && m_vk[v] == k) m_gate[v] = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    for (int v = 0; v < NV; v++) m_start[v] = 0;
    if (m_ext) begin
      if (!m_brk && b == 8'hF0) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (m_brk) begin
      m_brk = 0;
      model_break(lookup(b));
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else model_make(lookup(b));
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [9:0] k; logic [NV-1:0] g, s; logic [4*NV-1:0] vk;
    k = '0; g = '0; s = '0; vk = '0;
    for (int i = 0; i < 10; i++) k[i] = m_keys[i];
    for (int v = 0; v < NV; v++) begin
      g[v] = m_gate[v]; s[v] = m_start[v];
      if (m_gate[v]) vk[4*v +: 4] = 4'(m_vk[v]);
    end
    return {k, g, vk, s};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    logic [4*NV-1:0] mask;
    mask = '0;
    for (int v = 0; v < NV; v++) if (m_gate[v]) mask[4*v +: 4] = 4'hF;
    return {keys_out, voice_gate, voice_key & mask, voice_start};
  endfunction

  task automatic send(input logic [7:0] b);
    ps2_key_data = b;
    ps2_key_pressed = 1'b1;
    model_byte(b);
    @(posedge clock); #1;
    ps2_key_pressed = 1'b0;
  endtask

  task automatic idle();
    @(posedge clock); #1;
    for (int v = 0; v < NV; v++) m_start[v] = 0;
  endtask

  task automatic do_reset(input bit with_strobe, input logic [7:0] b);
    reset = 1'b1;
    if (with_strobe) begin ps2_key_data = b; ps2_key_pressed = 1'b1; end
    @(posedge clock); #1;
    reset = 1'b0;
    ps2_key_pressed = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(0, 8'h00);
    checks++; if (keys_out !== 10'h000) begin failures++; $display("FAIL reset_keys got=%h exp=000", keys_out); end
    checks++; if (voice_gate !== '0) begin failures++; $display("FAIL reset_gate got=%h exp=0", voice_gate); end
    checks++; if (voice_key !== '0) begin failures++; $display("FAIL reset_vkey got=%h exp=0", voice_key); end
    checks++; if (voice_start !== '0) begin failures++; $display("FAIL reset_start got=%h exp=0", voice_start); end
  endtask

  task automatic test_single();
    logic [7:0] seq [3] = '{8'h1A, 8'hF0, 8'h1A};
    do_reset(0, 8'h00);
    send(seq[0]);
    checks++; if (keys_out !== 10'h200 || voice_gate !== 4'b0001 || voice_key[3:0] !== 4'd9 || voice_start !== 4'b0001) begin
      failures++; $display("FAIL single_make got=%h/%h/%h/%h exp=200/1/9/1", keys_out, voice_gate, voice_key[3:0], voice_start); end
    idle();
    checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL single_pulse_end got=%h exp=%h", obs_vec(), exp_vec()); end
    for (int i = 1; i < 3; i++) begin
      send(seq[i]);
      checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL single_seq%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
    end
    checks++; if ({keys_out, voice_gate, voice_start} !== '0) begin failures++; $display("FAIL single_release got=%h exp=0", {keys_out, voice_gate, voice_start}); end
  endtask

  task automatic test_typematic();
    int pulses = 0;
    do_reset(0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      send(8'h22);
      if (voice_start != '0) pulses++;
      checks++; if (keys_out !== 10'h080) begin failures++; $display("FAIL typematic_keys%0d got=%h exp=080", i, keys_out); end
      checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL typematic%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
    end
    checks++; if (pulses !== 1 || voice_key[3:0] !== 4'd7) begin failures++; $display("FAIL typematic_pulses got=%0d/%0d exp=1/7", pulses, voice_key[3:0]); end
  endtask

  task automatic test_five_keys();
    logic [7:0] seq [4] = '{8'h31, 8'h33, 8'h32, 8'h34};
    do_reset(0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      send(seq[i]);
      checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL five_fill%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
    end
    checks++; if (voice_gate !== 4'hF || voice_key !== 16'h3210) begin failures++; $display("FAIL five_full got=%h/%h exp=f/3210", voice_gate, voice_key); end
    send(8'h2A);
    checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL five_fifth got=%h exp=%h", obs_vec(), exp_vec()); end
`ifdef VOICE_STEAL_EN
    checks++; if (voice_key[3:0] !== 4'd4 || voice_start !== 4'b0001 || voice_gate !== 4'hF) begin
      failures++; $display("FAIL five_steal got=%h/%h/%h exp=4/1/f", voice_key[3:0], voice_start, voice_gate); end
`else
    checks++; if (voice_key[3:0] !== 4'd0 || voice_start !== 4'b0000) begin
      failures++; $display("FAIL five_drop got=%h/%h exp=0/0", voice_key[3:0], voice_start); end
`endif
    checks++; if (keys_out !== 10'h01F) begin failures++; $display("FAIL five_keys got=%h exp=01f", keys_out); end
    send(8'hF0);
    send(8'h31);
    checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL five_release got=%h exp=%h", obs_vec(), exp_vec()); end
    checks++; if (keys_out !== 10'h01E) begin failures++; $display("FAIL five_release_keys got=%h exp=01e", keys_out); end
  endtask

  task automatic test_extended();
    logic [7:0] seq [6] = '{8'hE0, 8'h1A, 8'hE0, 8'hF0, 8'h1A, 8'h1C};
    do_reset(0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      send(seq[i]);
      checks++; if ({keys_out, voice_gate, voice_start} !== '0) begin failures++; $display("FAIL ext_quiet%0d got=%h exp=0", i, {keys_out, voice_gate, voice_start}); end
    end
    send(8'h1B);
    checks++; if (voice_gate !== 4'b0001 || voice_key[3:0] !== 4'd8 || voice_start !== 4'b0001) begin
      failures++; $display("FAIL ext_follow got=%h/%h/%h exp=1/8/1", voice_gate, voice_key[3:0], voice_start); end
  endtask

  task automatic test_reset_midseq();
    do_reset(0, 8'h00);
    send(8'h1B);
    send(8'hF0);
    do_reset(1, 8'h1B);
    checks++; if ({keys_out, voice_gate, voice_key, voice_start} !== '0) begin
      failures++; $display("FAIL midreset_clear got=%h exp=0", {keys_out, voice_gate, voice_key, voice_start}); end
    send(8'h1B);
    checks++; if (voice_gate !== 4'b0001 || voice_key[3:0] !== 4'd8 || keys_out !== 10'h100) begin
      failures++; $display("FAIL midreset_make got=%h/%h/%h exp=1/8/100", voice_gate, voice_key[3:0], keys_out); end
  endtask

  task automatic test_random();
    logic [7:0] ops[$];
    logic [7:0] unm [4] = '{8'h1C, 8'h15, 8'h00, 8'h5A};
    int r, k;
    do_reset(0, 8'h00);
    for (int n = 0; n < 400; n++) begin
      ops = {};
      r = int'($urandom_range(0, 99));
      k = int'($urandom_range(0, 9));
      if (r < 45)      ops = {codes[k]};
      else if (r < 80) ops = {8'hF0, codes[k]};
      else if (r < 85) ops = {8'hE0, codes[k]};
      else if (r < 90) ops = {8'hE0, 8'hF0, codes[k]};
      else             ops = {unm[$urandom_range(0, 3)]};
      foreach (ops[i]) begin
        send(ops[i]);
        checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL random op=%0d byte=%h got=%h exp=%h", n, ops[i], obs_vec(), exp_vec()); end
      end
      if ($urandom_range(0, 3) == 0) begin
        idle();
        checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL random_idle op=%0d got=%h exp=%h", n, obs_vec(), exp_vec()); end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_typematic();
    test_five_keys();
    test_extended();
    test_reset_midseq();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
